block_drawer: RTL
=================

# block_drawer

Rasterises one tower block into the VGA framebuffer, one pixel per clock, from a latched (x, y) base position. It reads the current block position held by the x/y position registers and writes the pixels to the VGA adapter's plot port. The game FSM starts it after every position update, first in erase mode to clear the old location, then in draw mode at the new one.

## Interface
- BLOCK_W, 16, block width in pixels (equal to UNIT_BLOCK)
- BLOCK_H, 8, block height in pixels
- X_MAX, 160, screen width; pixels at x ≥ X_MAX are clipped
- Y_MAX, 120, screen height; pixels at y ≥ Y_MAX are clipped
- BG_COLOUR, 3'b000, colour written in erase mode
- clk  input  1  50 MHz system clock
- resetn  input  1  reset; asynchronous, active-low
- start  input  1  request to render; sampled only in IDLE
- erase  input  1  sampled with start; 1 = fill with BG_COLOUR
- x_pos  input  8  block base x (left column)
- y_pos  input  7  block base y (top row), from curr_y_position
- colour  input  3  fill colour, sampled with start
- vga_x  output  8  pixel x to VGA adapter
- vga_y  output  7  pixel y to VGA adapter
- vga_colour  output  3  pixel colour
- plot  output  1  write strobe; vga_* valid when high
- busy  output  1  high from the cycle after start through the done cycle
- done  output  1  one-cycle pulse after the last pixel

## Operation
- FSM states: IDLE, DRAW, DONE.
- IDLE: on start=1, latch x_pos, y_pos, colour (or BG_COLOUR if erase=1), clear offsets; go to DRAW.
- DRAW: each cycle emit pixel (x_base+x_off, y_base+y_off); offsets advance row-major, x_off 0..BLOCK_W-1 inner, y_off 0..BLOCK_H-1 outer. After pixel (BLOCK_W-1, BLOCK_H-1) go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Arithmetic: sums formed as 9-bit (x) and 8-bit (y), unsigned. If sum ≥ X_MAX or ≥ Y_MAX, the pixel is clipped: plot=0 that cycle; counting continues, so total DRAW duration is fixed. No wrap-around onto the opposite screen edge.
- start while busy: ignored, no queuing. Inputs changing during DRAW: no effect (latched copy used).
- start asserted in the DONE cycle: ignored; accepted in the following IDLE cycle.
- Reset mid-draw: all outputs return to reset values immediately, FSM to IDLE; the partially drawn block is left in the framebuffer.
- Reset values: vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0.

## Timing
- All outputs registered.
- start sampled at edge N -> first pixel on outputs with plot=1 after edge N+1; pixel k (0-based) after edge N+1+k.
- Last pixel after edge N+BLOCK_W*BLOCK_H; done=1 after edge N+BLOCK_W*BLOCK_H+1; IDLE, ready for start, the following cycle.
- Default render: 128 pixel cycles + 1 done cycle; back-to-back start-to-start period 130 cycles.

## Configuration
- BLOCK_DRAWER_OUTLINE_EN defined: in draw mode, border pixels (x_off=0, x_off=BLOCK_W-1, y_off=0, y_off=BLOCK_H-1) use OUTLINE_COLOUR; interior uses colour. Erase mode remains solid BG_COLOUR.
- Undefined: solid fill with the latched colour. Timing is identical in both builds.

## Structure
- Shared package tower_pkg: X_MAX, Y_MAX, UNIT_BLOCK=16, Y_INIT=7'd104, BG_COLOUR, OUTLINE_COLOUR=3'b111, colour_t (3-bit), FSM state typedef.
- Sub-module pixel_offset_counter: 2-D row-major offset counter with clear, enable, and last-pixel flag; block_drawer owns the FSM, latching, clipping and output registers.

## Test plan
- Reset, then start with x_pos=0, y_pos=104, colour=3'b010, erase=0 -> 128 plots covering x 0..15, y 104..111, colour 010, row-major order; done pulses exactly at cycle 129 after start.
- Same position, erase=1 -> 128 plots, all vga_colour=000.
- x_pos=150, y_pos=116 -> plots only for x 150..159, y 116..119 (40 pixels); plot=0 on clipped cycles; done still at cycle 129.
- start re-asserted with x_pos=80 at pixel 50 of a render at x_pos=0 -> ignored, no x ≥ 80 output; a second start in the cycle after done -> render at x 80..95 begins.
- resetn dropped asynchronously at pixel 60 -> plot, busy, done, vga_* go to 0 without waiting for a clock edge; no done pulse; next start renders normally.
- With BLOCK_DRAWER_OUTLINE_EN, draw at (32, 40), colour=3'b001 -> border pixels 111, interior (x 33..46, y 41..46) 001.

Source files
------------

// File: rtl/tower_pkg.sv
// Shared tower-game constants, colour type and block-drawer FSM state encoding.
package tower_pkg;

  localparam int X_MAX        = 160;
  localparam int Y_MAX        = 120;
  localparam int UNIT_BLOCK   = 16;
  localparam int BLOCK_HEIGHT = 8;

  localparam logic [6:0] Y_INIT = 7'd104;

  typedef logic [2:0] colour_t;

  localparam colour_t BG_COLOUR      = 3'b000;
  localparam colour_t OUTLINE_COLOUR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } draw_state_t;

endpackage

// File: rtl/block_drawer_if.sv
// Request (game FSM -> drawer) and pixel/status (drawer -> VGA, FSM) signals.
interface block_drawer_if;
  import tower_pkg::*;

  logic       start;
  logic       erase;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  colour_t    colour;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  colour_t    vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, erase, x_pos, y_pos, colour,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport slave (
    input  start, erase, x_pos, y_pos, colour,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );

endinterface

// File: rtl/block_drawer_pixel_offset_counter.sv
// Row-major 2-D offset counter: x_off inner (0..W-1), y_off outer (0..H-1).
// clr has priority over en; last flags the final (W-1, H-1) position.
module pixel_offset_counter #(
  parameter int W  = 16,
  parameter int H  = 8,
  parameter int XW = 4,
  parameter int YW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          last
);

  logic x_end;
  logic y_end;

  assign x_end = (x_off == XW'(W - 1));
  assign y_end = (y_off == YW'(H - 1));
  assign last  = x_end & y_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_off <= '0;
      y_off <= '0;
    end else if (clr) begin
      x_off <= '0;
      y_off <= '0;
    end else if (en) begin
      if (x_end) begin
        x_off <= '0;
        y_off <= y_end ? '0 : y_off + YW'(1);
      end else begin
        x_off <= x_off + XW'(1);
      end
    end
  end

endmodule

// File: rtl/block_drawer.sv
// Rasterises one BLOCK_W x BLOCK_H block, one pixel per clock; first pixel two edges after start.
// No backpressure: start is ignored unless idle. BLOCK_DRAWER_OUTLINE_EN adds a border colour.
module block_drawer
  import tower_pkg::*;
#(
  parameter int      BLOCK_W   = tower_pkg::UNIT_BLOCK,
  parameter int      BLOCK_H   = tower_pkg::BLOCK_HEIGHT,
  parameter int      X_MAX     = tower_pkg::X_MAX,
  parameter int      Y_MAX     = tower_pkg::Y_MAX,
  parameter colour_t BG_COLOUR = tower_pkg::BG_COLOUR
) (
  input  logic          clk,
  input  logic          resetn,
  block_drawer_if.slave bus
);

  localparam int XW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam int YW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

  draw_state_t state_q;
  draw_state_t state_nxt;
  logic        latch_en;
  logic        cnt_clr;
  logic        cnt_en;

  logic [7:0]    x_base;
  logic [6:0]    y_base;
  colour_t       colour_q;
  logic [XW-1:0] x_off;
  logic [YW-1:0] y_off;
  logic          last;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       in_view;
  colour_t    pix_colour;

  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  colour_t    vga_colour_q;
  logic       plot_q;
  logic       busy_q;
  logic       done_q;

  pixel_offset_counter #(
    .W  (BLOCK_W),
    .H  (BLOCK_H),
    .XW (XW),
    .YW (YW)
  ) u_offset (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .x_off  (x_off),
    .y_off  (y_off),
    .last   (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    latch_en  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = DRAW;
          latch_en  = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      DRAW: begin
        cnt_en = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_base   <= '0;
      y_base   <= '0;
      colour_q <= '0;
    end else if (latch_en) begin
      x_base   <= bus.x_pos;
      y_base   <= bus.y_pos;
      colour_q <= bus.erase ? BG_COLOUR : bus.colour;
    end
  end

  // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
  assign x_sum   = {1'b0, x_base} + 9'(x_off);
  assign y_sum   = {1'b0, y_base} + 8'(y_off);
  assign in_view = (x_sum < 9'(X_MAX)) && (y_sum < 8'(Y_MAX));

`ifdef BLOCK_DRAWER_OUTLINE_EN
  logic erase_q;
  logic border;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      erase_q <= 1'b0;
    end else if (latch_en) begin
      erase_q <= bus.erase;
    end
  end

  assign border     = (x_off == '0) || (x_off == XW'(BLOCK_W - 1)) ||
                      (y_off == '0) || (y_off == YW'(BLOCK_H - 1));
  assign pix_colour = (!erase_q && border) ? OUTLINE_COLOUR : colour_q;
`else
  assign pix_colour = colour_q;
`endif

  // busy stays high through the cycle that shows done, and across a back-to-back restart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      plot_q <= (state_q == DRAW) && in_view;
      done_q <= (state_q == DONE);
      busy_q <= (state_nxt != IDLE) || (state_q == DONE);
      if (state_q == DRAW) begin
        vga_x_q      <= x_sum[7:0];
        vga_y_q      <= y_sum[6:0];
        vga_colour_q <= pix_colour;
      end
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
